// File: rtl/timer_dev.sv
// Programmable 32-bit countdown timer with one-shot / auto-reload modes and a maskable interrupt.
// Software drives it through a four-word register window: CTRL, PRESET, COUNT and an unused slot.
module timer_dev #(
    parameter logic [31:0] DEFAULT_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:2]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic        en, en_nx;
    logic [1:0]  mode, mode_nx;
    logic        im, im_nx;
    logic [31:0] preset, preset_nx;
    logic [31:0] count, count_nx;
    logic        irq_pend, irq_pend_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            en       <= 1'b0;
            mode     <= 2'b00;
            im       <= 1'b0;
            preset   <= DEFAULT_PRESET;
            count    <= 32'd0;
            irq_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            en       <= en_nx;
            mode     <= mode_nx;
            im       <= im_nx;
            preset   <= preset_nx;
            count    <= count_nx;
            irq_pend <= irq_pend_nx;
        end
    end

    // Bus writes are applied after the FSM so a CTRL write overrides the one-shot EN clear.
    always_comb begin
        state_nx    = state;
        en_nx       = en;
        mode_nx     = mode;
        im_nx       = im;
        preset_nx   = preset;
        count_nx    = count;
        irq_pend_nx = irq_pend;

        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                count_nx = preset;
                state_nx = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (count == 32'd0) begin
                    state_nx    = INT;
                    irq_pend_nx = 1'b1;
                end else begin
                    count_nx = count - 32'd1;
                end
            end
            INT: begin
                if (mode == 2'b01) begin
                    irq_pend_nx = 1'b0;
                    state_nx    = LOAD;
                end else begin
                    en_nx    = 1'b0;
                    state_nx = IDLE;
                end
            end
        endcase

        if (WE) begin
            case (Addr)
                2'd0: begin
                    en_nx       = DIn[0];
                    mode_nx     = DIn[2:1];
                    im_nx       = DIn[3];
                    irq_pend_nx = 1'b0;
                end
                2'd1: begin
                    preset_nx   = DIn;
                    irq_pend_nx = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (Addr)
            2'd0:    DOut = {28'd0, im, mode, en};
            2'd1:    DOut = preset;
            2'd2:    DOut = count;
            default: DOut = 32'd0;
        endcase
    end

    assign IRQ = irq_pend & im;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: an elapsed-time model checked every cycle,
// plus directed scenarios with hand-computed register and interrupt values.
module tb_timer_dev;

    localparam logic [31:0] DEF = 32'h0000_0007;

    logic        clk;
    logic        reset;
    logic [3:2]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int vectors;
    int miscompares;
    bit checkOn;

    // Model: mK counts edges since the timer left idle (-1 = idle), mP is the loaded period.
    logic        mEn;
    logic [1:0]  mMode;
    logic        mIm;
    logic [31:0] mPreset;
    logic [31:0] mCount;
    logic        mPend;
    longint      mK;
    longint      mP;

    timer_dev #(.DEFAULT_PRESET(DEF)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .DIn   (DIn),
        .DOut  (DOut),
        .IRQ   (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic logic [31:0] modelDout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, mIm, mMode, mEn};
            2'd1:    return mPreset;
            2'd2:    return mCount;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic        nEn;
        logic        nPend;
        logic [31:0] nCount;
        longint      nK;
        longint      nP;
        if (reset) begin
            mEn = 1'b0; mMode = 2'b00; mIm = 1'b0; mPreset = DEF;
            mCount = 32'd0; mPend = 1'b0; mK = -1; mP = 0;
        end else begin
            nEn = mEn; nPend = mPend; nCount = mCount; nK = mK; nP = mP;
            if (mK < 0) begin
                if (mEn) nK = 0;
            end else if (mK == 0) begin
                nP = longint'(mPreset);
                nCount = mPreset;
                nK = 1;
            end else if (mK <= mP + 1) begin
                if (!mEn) begin
                    nK = -1;
                end else if (mK == mP + 1) begin
                    nPend = 1'b1;
                    nK = mK + 1;
                end else begin
                    nCount = 32'(mP - mK);
                    nK = mK + 1;
                end
            end else begin
                if (mMode == 2'b01) begin
                    nPend = 1'b0;
                    nK = 0;
                end else begin
                    nEn = 1'b0;
                    nK = -1;
                end
            end
            if (WE && Addr == 2'd0) begin
                nEn = DIn[0]; mMode = DIn[2:1]; mIm = DIn[3]; nPend = 1'b0;
            end else if (WE && Addr == 2'd1) begin
                mPreset = DIn; nPend = 1'b0;
            end
            mEn = nEn; mPend = nPend; mCount = nCount; mK = nK; mP = nP;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("cycle_dout", DOut, modelDout(Addr));
            checkOutput("cycle_irq", {31'd0, IRQ}, {31'd0, mPend & mIm});
        end
    end

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic expectReg(input logic [1:0] a, input string name, input logic [31:0] exp);
        Addr = a;
        #1;
        checkOutput(name, DOut, exp);
        checkOutput({name, "_model"}, modelDout(a), exp);
    endtask

    task automatic expectIrq(input string name, input logic exp);
        checkOutput(name, {31'd0, IRQ}, {31'd0, exp});
        checkOutput({name, "_model"}, {31'd0, mPend & mIm}, {31'd0, exp});
    endtask

    task automatic expectResetState(input string tag);
        expectReg(2'd0, {tag, "_ctrl"}, 32'd0);
        expectReg(2'd1, {tag, "_preset"}, DEF);
        expectReg(2'd2, {tag, "_count"}, 32'd0);
        expectReg(2'd3, {tag, "_unused"}, 32'd0);
        expectIrq({tag, "_irq"}, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        checkOn = 1'b0;
        reset = 1'b1;
        WE = 1'b0;
        Addr = 2'd0;
        DIn = 32'd0;
        doReset();
        checkOn = 1'b1;

        $display("[TB] reset values");
        expectResetState("rst");

        $display("[TB] one-shot, PRESET=5, CTRL=0x9");
        applyStimulus(2'd1, 32'd5);
        applyStimulus(2'd0, 32'h9);
        waitEdges(2);  expectReg(2'd2, "m0_count_e2", 32'd5);
        waitEdges(5);  expectReg(2'd2, "m0_count_e7", 32'd0);
        expectIrq("m0_irq_e7", 1'b0);
        waitEdges(1);  expectIrq("m0_irq_e8", 1'b1);
        waitEdges(1);  expectIrq("m0_irq_e9", 1'b1);
        expectReg(2'd0, "m0_ctrl_e9", 32'h8);
        waitEdges(3);  expectIrq("m0_irq_hold", 1'b1);
        applyStimulus(2'd0, 32'h8);
        expectIrq("m0_irq_cleared", 1'b0);

        $display("[TB] auto-reload, PRESET=3, CTRL=0xB");
        doReset();
        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd0, 32'hB);
        for (int e = 1; e <= 20; e++) begin
            waitEdges(1);
            expectIrq("m1_irq", (e == 6 || e == 12 || e == 18));
            if (e == 8 || e == 14) expectReg(2'd2, "m1_reload", 32'd3);
        end

        $display("[TB] one-shot with IM=0, PRESET=4");
        doReset();
        applyStimulus(2'd1, 32'd4);
        applyStimulus(2'd0, 32'h1);
        waitEdges(9);
        expectIrq("im0_irq_expired", 1'b0);
        expectReg(2'd0, "im0_ctrl", 32'h0);
        applyStimulus(2'd0, 32'h8);
        expectIrq("im0_irq_after_clear", 1'b0);
        expectReg(2'd0, "im0_ctrl_im", 32'h8);
        waitEdges(2);  expectIrq("im0_irq_hold", 1'b0);
        applyStimulus(2'd0, 32'h1);
        waitEdges(3);
        applyStimulus(2'd0, 32'h9);
        waitEdges(2);  expectIrq("im1_irq_e6", 1'b0);
        waitEdges(1);  expectIrq("im1_irq_e7", 1'b1);

        $display("[TB] mid-count disable, re-enable and reset");
        doReset();
        applyStimulus(2'd1, 32'd10);
        applyStimulus(2'd0, 32'h1);
        waitEdges(5);  expectReg(2'd2, "mid_count_e5", 32'd7);
        applyStimulus(2'd0, 32'h0);
        expectReg(2'd2, "mid_count_stop", 32'd6);
        waitEdges(3);  expectReg(2'd2, "mid_count_held", 32'd6);
        expectReg(2'd0, "mid_ctrl_off", 32'h0);
        applyStimulus(2'd0, 32'h1);
        waitEdges(2);  expectReg(2'd2, "mid_reload", 32'd10);
        waitEdges(7);  expectReg(2'd2, "mid_count_3", 32'd3);
        doReset();
        expectResetState("midrst");

        $display("[TB] ignored writes to COUNT and Addr 3");
        applyStimulus(2'd0, 32'h1);
        waitEdges(1);
        applyStimulus(2'd2, 32'h0000_FFFF);
        expectReg(2'd2, "ign_count_e2", 32'd7);
        applyStimulus(2'd3, 32'h0000_FFFF);
        expectReg(2'd2, "ign_count_e3", 32'd6);
        expectReg(2'd3, "ign_unused", 32'd0);
        applyStimulus(2'd1, 32'd100);
        expectReg(2'd2, "ign_count_e4", 32'd5);
        expectReg(2'd1, "ign_preset", 32'd100);
        waitEdges(1);  expectReg(2'd2, "ign_count_e5", 32'd4);

        $display("[TB] PRESET=0, MODE=10, CTRL write during expiry");
        doReset();
        applyStimulus(2'd1, 32'd0);
        applyStimulus(2'd0, 32'hD);
        waitEdges(2);  expectIrq("p0_irq_e2", 1'b0);
        waitEdges(1);  expectIrq("p0_irq_e3", 1'b1);
        applyStimulus(2'd0, 32'hD);
        expectReg(2'd0, "p0_ctrl_wins", 32'hD);
        expectIrq("p0_irq_e4", 1'b0);
        waitEdges(3);  expectIrq("p0_irq_e7", 1'b1);

        waitEdges(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
